// File: rtl/axis_cmd_gen_mm2s.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_cmd_gen_mm2s                                               |
// | Purpose  : DataMover MM2S command generator / status monitor for playback  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axis_cmd_gen_mm2s #(
  parameter int PACKET_SIZE     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        axilite_clk,
  input  logic        axilite_rstb,
  input  logic        read_start,
  input  logic        read_reset,
  input  logic        loop_en,
  input  logic [31:0] base_addr,
  input  logic [31:0] play_size,
  output logic [71:0] m_axis_cmd_tdata,
  output logic        m_axis_cmd_tvalid,
  input  logic        m_axis_cmd_tready,
  input  logic [7:0]  s_axis_sts_tdata,
  input  logic        s_axis_sts_tvalid,
  output logic        s_axis_sts_tready,
  output logic [31:0] current_addr,
  output logic [7:0]  loop_count,
  output logic [3:0]  outstanding,
  output logic        busy,
  output logic        play_done,
  output logic        play_err,
  output logic [7:0]  err_status
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] c_packet = 32'(PACKET_SIZE);
  localparam logic [3:0]  c_max    = 4'(MAX_OUTSTANDING);

  state_t      r_state;
  logic [31:0] r_base;
  logic [31:0] r_size;
  logic [31:0] r_addr;
  logic [31:0] r_remaining;
  logic [3:0]  r_tag;
  logic [3:0]  r_exp_tag;
  logic [3:0]  r_outstanding;
  logic        r_cmd_valid;
  logic [71:0] r_cmd_data;
  logic [31:0] r_current_addr;
  logic [7:0]  r_loop_count;
  logic        r_play_done;
  logic        r_play_err;
  logic [7:0]  r_err_status;

  logic        w_cmd_hs;
  logic        w_sts_hs;
  logic        w_last_hs;
  logic        w_wrap;
  logic        w_sts_err;
  logic        w_out_dec;
  logic [3:0]  w_out_next;
  logic [31:0] w_src_addr;
  logic [31:0] w_src_rem;
  logic [31:0] w_btt;
  logic        w_eof;
  logic        w_load;
  logic        w_start;
  logic [71:0] w_next_cmd;

  assign w_cmd_hs  = r_cmd_valid & m_axis_cmd_tready;
  assign w_sts_hs  = s_axis_sts_tvalid;
  assign w_last_hs = w_cmd_hs & r_cmd_data[30];
  assign w_wrap    = w_last_hs & loop_en & (r_state == S_ISSUE);

  assign w_sts_err = w_sts_hs & ((s_axis_sts_tdata[3:0] != r_exp_tag) |
                                 (|s_axis_sts_tdata[6:4]) |
                                 ~s_axis_sts_tdata[7] |
                                 (r_outstanding == 4'd0));
  assign w_out_dec  = w_sts_hs & (r_outstanding != 4'd0);
  assign w_out_next = r_outstanding + {3'b000, w_cmd_hs} - {3'b000, w_out_dec};

  // On a looping last-chunk handshake the next command is built straight from
  // base/size so a wrap costs no idle cycle.
  assign w_src_addr = w_wrap ? r_base : r_addr;
  assign w_src_rem  = w_wrap ? r_size : r_remaining;
  assign w_btt      = (w_src_rem > c_packet) ? c_packet : w_src_rem;
  assign w_eof      = (w_src_rem == w_btt);
  assign w_next_cmd = {4'b0000, r_tag, w_src_addr, 1'b0, w_eof, 6'b000000, 1'b1, w_btt[22:0]};

  // The outstanding limit uses next-cycle occupancy so the loaded command can
  // never push the in-flight count past MAX_OUTSTANDING when it is accepted.
  assign w_load = (r_state == S_ISSUE) & ~w_sts_err & (~r_cmd_valid | w_cmd_hs) &
                  (w_src_rem != 32'd0) & (w_out_next < c_max);

  assign w_start = read_start & (play_size != 32'd0) &
                   ((r_state == S_IDLE) | (r_state == S_DONE));

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      r_state        <= S_IDLE;
      r_base         <= 32'd0;
      r_size         <= 32'd0;
      r_addr         <= 32'd0;
      r_remaining    <= 32'd0;
      r_tag          <= 4'd0;
      r_exp_tag      <= 4'd0;
      r_outstanding  <= 4'd0;
      r_cmd_valid    <= 1'b0;
      r_cmd_data     <= 72'd0;
      r_current_addr <= 32'd0;
      r_loop_count   <= 8'd0;
      r_play_done    <= 1'b0;
      r_play_err     <= 1'b0;
      r_err_status   <= 8'd0;
    end else if (read_reset) begin
      r_state        <= S_IDLE;
      r_base         <= 32'd0;
      r_size         <= 32'd0;
      r_addr         <= 32'd0;
      r_remaining    <= 32'd0;
      r_tag          <= 4'd0;
      r_exp_tag      <= 4'd0;
      r_outstanding  <= 4'd0;
      r_cmd_valid    <= 1'b0;
      r_cmd_data     <= 72'd0;
      r_current_addr <= 32'd0;
      r_loop_count   <= 8'd0;
      r_play_done    <= 1'b0;
      r_play_err     <= 1'b0;
      r_err_status   <= 8'd0;
    end else begin
      r_outstanding <= w_out_next;

      if (w_sts_hs) begin
        r_exp_tag <= r_exp_tag + 4'd1;
      end

      if (w_cmd_hs) begin
        r_current_addr <= r_cmd_data[63:32];
      end

      if (w_wrap) begin
        r_loop_count <= r_loop_count + 8'd1;
        r_addr       <= r_base;
        r_remaining  <= r_size;
      end

      if (w_load) begin
        r_cmd_valid <= 1'b1;
        r_cmd_data  <= w_next_cmd;
        r_tag       <= r_tag + 4'd1;
        r_addr      <= w_src_addr + w_btt;
        r_remaining <= w_src_rem - w_btt;
      end else if (w_cmd_hs) begin
        r_cmd_valid <= 1'b0;
      end

      // Only the first offending status word is kept.
      if (w_sts_err && (r_state != S_ERROR)) begin
        r_state      <= S_ERROR;
        r_play_err   <= 1'b1;
        r_err_status <= s_axis_sts_tdata;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_start) begin
              r_state     <= S_ISSUE;
              r_base      <= base_addr;
              r_size      <= play_size;
              r_addr      <= base_addr;
              r_remaining <= play_size;
              r_play_done <= 1'b0;
            end
          end
          S_ISSUE: begin
            if (w_last_hs && !loop_en) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_outstanding == 4'd0) begin
              r_state     <= S_DONE;
              r_play_done <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign m_axis_cmd_tdata  = r_cmd_data;
  assign m_axis_cmd_tvalid = r_cmd_valid;
  assign s_axis_sts_tready = 1'b1;
  assign current_addr      = r_current_addr;
  assign loop_count        = r_loop_count;
  assign outstanding       = r_outstanding;
  assign busy              = (r_state == S_ISSUE) | (r_state == S_DRAIN);
  assign play_done         = r_play_done;
  assign play_err          = r_play_err;
  assign err_status        = r_err_status;

endmodule
`default_nettype wire

// File: tb/tb_axis_cmd_gen_mm2s.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_cmd_gen_mm2s                                            |
// | Purpose  : Scoreboard bench for the MM2S command generator                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axis_cmd_gen_mm2s;

  localparam int         PACKET_SIZE     = 4096;
  localparam int         MAX_OUTSTANDING = 4;
  localparam logic [3:0] c_sts_okay      = 4'b1000;
  localparam logic [3:0] c_sts_slverr    = 4'b0100;
  localparam int         c_unlimited     = 32'h3fff_ffff;

  logic        axilite_clk  = 1'b0;
  logic        axilite_rstb = 1'b0;
  logic        read_start   = 1'b0;
  logic        read_reset   = 1'b0;
  logic        loop_en      = 1'b0;
  logic [31:0] base_addr    = 32'd0;
  logic [31:0] play_size    = 32'd0;
  logic [71:0] m_axis_cmd_tdata;
  logic        m_axis_cmd_tvalid;
  logic        m_axis_cmd_tready;
  logic [7:0]  s_axis_sts_tdata;
  logic        s_axis_sts_tvalid;
  logic        s_axis_sts_tready;
  logic [31:0] current_addr;
  logic [7:0]  loop_count;
  logic [3:0]  outstanding;
  logic        busy;
  logic        play_done;
  logic        play_err;
  logic [7:0]  err_status;

  always #5 axilite_clk = ~axilite_clk;

  axis_cmd_gen_mm2s #(
    .PACKET_SIZE     (PACKET_SIZE),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .axilite_clk       (axilite_clk),
    .axilite_rstb      (axilite_rstb),
    .read_start        (read_start),
    .read_reset        (read_reset),
    .loop_en           (loop_en),
    .base_addr         (base_addr),
    .play_size         (play_size),
    .m_axis_cmd_tdata  (m_axis_cmd_tdata),
    .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
    .m_axis_cmd_tready (m_axis_cmd_tready),
    .s_axis_sts_tdata  (s_axis_sts_tdata),
    .s_axis_sts_tvalid (s_axis_sts_tvalid),
    .s_axis_sts_tready (s_axis_sts_tready),
    .current_addr      (current_addr),
    .loop_count        (loop_count),
    .outstanding       (outstanding),
    .busy              (busy),
    .play_done         (play_done),
    .play_err          (play_err),
    .err_status        (err_status)
  );

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_cmds    = 0;
  int          sts_sent  = 0;
  int          sts_limit = 0;
  logic [3:0]  sts_code  = c_sts_okay;
  logic        ready_rand  = 1'b0;
  logic        ready_fixed = 1'b1;
  logic [3:0]  model_tag = 4'd0;
  logic [71:0] exp_cmds[$];
  logic [3:0]  pending[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected commands for one pass, in issue order.
  task automatic push_pass(input logic [31:0] base, input logic [31:0] size);
    logic [31:0] addr;
    logic [31:0] rem;
    logic [31:0] btt;
    addr = base;
    rem  = size;
    while (rem != 32'd0) begin
      btt = (rem > 32'(PACKET_SIZE)) ? 32'(PACKET_SIZE) : rem;
      exp_cmds.push_back({4'b0000, model_tag, addr, 1'b0, (rem == btt), 6'b000000, 1'b1, btt[22:0]});
      model_tag = model_tag + 4'd1;
      addr      = addr + btt;
      rem       = rem - btt;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge axilite_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] size, input logic lp);
    base_addr  = base;
    play_size  = size;
    loop_en    = lp;
    read_start = 1'b1;
    tick(1);
    read_start = 1'b0;
  endtask

  task automatic do_read_reset();
    read_reset = 1'b1;
    tick(1);
    read_reset = 1'b0;
    exp_cmds.delete();
    pending.delete();
    model_tag = 4'd0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (play_done) break;
      @(negedge axilite_clk);
    end
    check(tag, 72'(play_done), 72'd1);
  endtask

  task automatic wait_sent(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sts_sent >= target) break;
      @(negedge axilite_clk);
    end
    check(tag, 72'(sts_sent >= target), 72'd1);
  endtask

  task automatic wait_loops(input string tag, input logic [7:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (loop_count >= target) break;
      @(negedge axilite_clk);
    end
    check(tag, 72'(loop_count >= target), 72'd1);
  endtask

  // Command monitor: scoreboard compare, hold-stability check, tag capture.
  initial begin
    logic        prev_stall;
    logic [71:0] prev_data;
    logic [71:0] exp;
    prev_stall = 1'b0;
    prev_data  = 72'd0;
    forever begin
      @(negedge axilite_clk);
      if (!axilite_rstb || read_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 72'(m_axis_cmd_tvalid), 72'd1);
          check("hold_data", m_axis_cmd_tdata, prev_data);
        end
        if (m_axis_cmd_tvalid && m_axis_cmd_tready) begin
          n_cmds++;
          pending.push_back(m_axis_cmd_tdata[67:64]);
          if (exp_cmds.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL cmd_extra: observed %0h expected no command", m_axis_cmd_tdata);
          end else begin
            exp = exp_cmds.pop_front();
            check("cmd", m_axis_cmd_tdata, exp);
          end
        end
        prev_stall = m_axis_cmd_tvalid && !m_axis_cmd_tready;
        prev_data  = m_axis_cmd_tdata;
      end
    end
  end

  // Status responder: answers captured tags, gated by sts_limit.
  initial begin
    logic [3:0] t;
    s_axis_sts_tvalid = 1'b0;
    s_axis_sts_tdata  = 8'd0;
    forever begin
      @(posedge axilite_clk);
      #1;
      if (sts_sent < sts_limit && pending.size() > 0) begin
        t                 = pending.pop_front();
        s_axis_sts_tdata  = {sts_code, t};
        s_axis_sts_tvalid = 1'b1;
        sts_sent++;
      end else begin
        s_axis_sts_tvalid = 1'b0;
      end
    end
  end

  initial begin
    m_axis_cmd_tready = 1'b1;
    forever begin
      @(posedge axilite_clk);
      #1;
      m_axis_cmd_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_n;
    int target;

    repeat (3) @(negedge axilite_clk);
    axilite_rstb = 1'b1;
    @(negedge axilite_clk);
    check("rst_outs", 72'({current_addr, loop_count, outstanding, busy, play_done,
                           play_err, err_status, m_axis_cmd_tvalid}), 72'd0);
    check("rst_tdata", m_axis_cmd_tdata, 72'd0);
    check("rst_sts_tready", 72'(s_axis_sts_tready), 72'd1);

    tick(1);
    start(32'h1000_0000, 32'd0, 1'b0);
    tick(2);
    @(negedge axilite_clk);
    check("zero_size_busy", 72'(busy), 72'd0);

    // Basic three-chunk pass.
    tick(1);
    sts_limit = c_unlimited;
    base_n    = n_cmds;
    push_pass(32'h1000_0000, 32'd10000);
    start(32'h1000_0000, 32'd10000, 1'b0);
    wait_done("t1_done", 200);
    @(negedge axilite_clk);
    check("t1_count", 72'(n_cmds - base_n), 72'd3);
    check("t1_busy", 72'(busy), 72'd0);
    check("t1_outstanding", 72'(outstanding), 72'd0);
    check("t1_current_addr", 72'(current_addr), 72'h1000_2000);
    check("t1_sb_empty", 72'(exp_cmds.size()), 72'd0);

    // Outstanding limit with statuses withheld.
    tick(1);
    sts_limit = sts_sent;
    base_n    = n_cmds;
    push_pass(32'h1100_0000, 32'd32768);
    start(32'h1100_0000, 32'd32768, 1'b0);
    repeat (20) @(negedge axilite_clk);
    check("t2_issued", 72'(n_cmds - base_n), 72'd4);
    check("t2_outstanding", 72'(outstanding), 72'd4);
    check("t2_tvalid_low", 72'(m_axis_cmd_tvalid), 72'd0);
    target    = sts_sent + 1;
    sts_limit = target;
    wait_sent("t2_sts_sent", target, 20);
    check("t2_tvalid_before", 72'(m_axis_cmd_tvalid), 72'd0);
    @(negedge axilite_clk);
    check("t2_tvalid_next", 72'(m_axis_cmd_tvalid), 72'd1);
    check("t2_outstanding_dec", 72'(outstanding), 72'd3);
    sts_limit = c_unlimited;
    wait_done("t2_done", 300);
    @(negedge axilite_clk);
    check("t2_count", 72'(n_cmds - base_n), 72'd8);
    check("t2_sb_empty", 72'(exp_cmds.size()), 72'd0);

    // Random backpressure.
    tick(1);
    ready_rand = 1'b1;
    base_n     = n_cmds;
    push_pass(32'h2000_0000, 32'd20580);
    start(32'h2000_0000, 32'd20580, 1'b0);
    wait_done("t3_done", 2000);
    ready_rand = 1'b0;
    @(negedge axilite_clk);
    check("t3_count", 72'(n_cmds - base_n), 72'd6);
    check("t3_sb_empty", 72'(exp_cmds.size()), 72'd0);
    check("t3_current_addr", 72'(current_addr), 72'h2000_5000);

    // Loop playback, loop_en dropped after three passes.
    tick(1);
    base_n = n_cmds;
    for (int p = 0; p < 4; p++) push_pass(32'h3000_0000, 32'd8192);
    start(32'h3000_0000, 32'd8192, 1'b1);
    wait_loops("t4_loops", 8'd3, 1000);
    loop_en = 1'b0;
    wait_done("t4_done", 500);
    @(negedge axilite_clk);
    check("t4_loop_count", 72'(loop_count), 72'd3);
    check("t4_count", 72'(n_cmds - base_n), 72'd8);
    check("t4_sb_empty", 72'(exp_cmds.size()), 72'd0);
    check("t4_current_addr", 72'(current_addr), 72'h3000_1000);

    // SLVERR status handling.
    tick(1);
    do_read_reset();
    @(negedge axilite_clk);
    check("rr_loop_count", 72'(loop_count), 72'd0);
    check("rr_play_done", 72'(play_done), 72'd0);
    sts_limit = sts_sent;
    base_n    = n_cmds;
    push_pass(32'h4000_0000, 32'd32768);
    start(32'h4000_0000, 32'd32768, 1'b0);
    repeat (20) @(negedge axilite_clk);
    check("t5_outstanding_full", 72'(outstanding), 72'd4);
    sts_code  = c_sts_okay;
    target    = sts_sent + 1;
    sts_limit = target;
    wait_sent("t5_sts_ok", target, 20);
    repeat (5) @(negedge axilite_clk);
    check("t5_issued", 72'(n_cmds - base_n), 72'd5);
    sts_code  = c_sts_slverr;
    target    = sts_sent + 1;
    sts_limit = target;
    wait_sent("t5_sts_err", target, 20);
    repeat (3) @(negedge axilite_clk);
    check("t5_play_err", 72'(play_err), 72'd1);
    check("t5_err_status", 72'(err_status), 72'h41);
    check("t5_tvalid", 72'(m_axis_cmd_tvalid), 72'd0);
    check("t5_busy", 72'(busy), 72'd0);
    check("t5_outstanding", 72'(outstanding), 72'd3);
    repeat (10) @(negedge axilite_clk);
    check("t5_no_more_cmds", 72'(n_cmds - base_n), 72'd5);
    sts_code  = c_sts_okay;
    target    = sts_sent + 1;
    sts_limit = target;
    wait_sent("t5_sts_after", target, 20);
    repeat (3) @(negedge axilite_clk);
    check("t5_outstanding_track", 72'(outstanding), 72'd2);
    check("t5_err_status_kept", 72'(err_status), 72'h41);
    tick(1);
    do_read_reset();
    @(negedge axilite_clk);
    check("t5_rr_outs", 72'({current_addr, loop_count, outstanding, busy, play_done,
                             play_err, err_status, m_axis_cmd_tvalid}), 72'd0);

    // Asynchronous reset while a command is stalled.
    tick(1);
    ready_fixed = 1'b0;
    sts_limit   = sts_sent;
    tick(1);
    start(32'h4800_0000, 32'd8192, 1'b0);
    repeat (5) @(negedge axilite_clk);
    check("t6_stalled_valid", 72'(m_axis_cmd_tvalid), 72'd1);
    #2;
    axilite_rstb = 1'b0;
    #1;
    check("t6_async_outs", 72'({current_addr, loop_count, outstanding, busy, play_done,
                                play_err, err_status, m_axis_cmd_tvalid}), 72'd0);
    check("t6_async_tdata", m_axis_cmd_tdata, 72'd0);
    check("t6_async_sts_tready", 72'(s_axis_sts_tready), 72'd1);
    @(negedge axilite_clk);
    axilite_rstb = 1'b1;
    exp_cmds.delete();
    pending.delete();
    model_tag   = 4'd0;
    ready_fixed = 1'b1;
    sts_limit   = c_unlimited;
    tick(2);
    base_n = n_cmds;
    push_pass(32'h5000_0000, 32'd8192);
    start(32'h5000_0000, 32'd8192, 1'b0);
    wait_done("t6_done", 200);
    @(negedge axilite_clk);
    check("t6_count", 72'(n_cmds - base_n), 72'd2);
    check("t6_sb_empty", 72'(exp_cmds.size()), 72'd0);
    check("t6_current_addr", 72'(current_addr), 72'h5000_1000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
